output_memory_banked: RTL and testbench
=======================================

Name: output_memory_banked

Overview:
- Next-generation on-chip result SRAM for the conv/MLP engines.
- Generalises the single flat output store into NBANK single-port banks with parametrised word width and depth.
- Adds valid/ready write and read handshakes with bank-conflict stalls, a hardware zero-fill (clear) sequencer, and sticky out-of-range error reporting.
- The write port is driven by the DSU. The read port serves CPU/DMA readback.

Parameters:
- DW, 32, data word width in bits
- DEPTH, 301056, total words (56×56×96); need not be a multiple of NBANK
- NBANK, 4, number of banks; power of 2, ≥2
- AW, $clog2(DEPTH) (=19), word address width
- ROWS, ceil(DEPTH/NBANK), derived; rows per bank
- RW, $clog2(ROWS), derived; row address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- clr_start  in  1  pulse; start zero-fill of the entire memory
- clr_busy  out  1  zero-fill in progress
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted this cycle when wr_valid&wr_ready
- wr_addr  in  AW  word address
- wr_data  in  DW  write data
- rd_valid_in  in  1  read request
- rd_ready  out  1  read request accepted this cycle
- rd_addr  in  AW  word address
- rd_data  out  DW  read data
- rd_valid  out  1  rd_data valid (1-cycle pulse)
- err_oor  out  1  sticky: an access with addr ≥ DEPTH was accepted
- rd_parity_err  out  1  parity error on current rd_data (feature only)

Behaviour:
- Mapping: bank = addr[log2(NBANK)-1:0], row = addr >> log2(NBANK).
- Each bank performs one access per cycle.
- Reset (async, rst=1) values:
  - rd_data=0, rd_valid=0, clr_busy=0, err_oor=0, rd_parity_err=0.
  - FSM goes to IDLE.
  - Array contents are not reset.
- FSM states: IDLE, CLEAR.
- IDLE:
  - wr_ready=1.
  - rd_ready=1 unless wr_valid=1 and the write bank equals the read bank (bank conflict: write wins, read stalls, rd_ready=0).
  - Reads to a different bank than the write proceed in parallel.
- IDLE→CLEAR on clr_start:
  - clr_busy=1 from the next cycle.
  - err_oor cleared.
  - A write or read handshaking in the same cycle as clr_start still completes.
- CLEAR:
  - Row counter runs 0..ROWS-1; zero is written to all banks at that row each cycle.
  - Takes ROWS cycles (75264 at default).
  - wr_ready=0 and rd_ready=0 throughout.
  - clr_start while busy is ignored.
  - CLEAR→IDLE after row ROWS-1 is written; clr_busy=0 on the following cycle.
- Read latency: request accepted at edge N → rd_data/rd_valid at edge N+1.
  - rd_data holds its value until the next accepted read.
  - rd_valid is high for exactly one cycle per accepted read.
- Write-then-read same address in consecutive cycles: the read returns the new data (no bypass needed).
- Same-cycle write and read to the same address: this is a bank conflict. The read stalls one cycle, then returns the new data.
- Out of range (addr ≥ DEPTH, including addresses in the unused partial last row):
  - Out-of-range write: handshake completes, array is unmodified, err_oor is set.
  - Out-of-range read: handshake completes, rd_data=0, rd_valid=1, err_oor is set.
- Reset asserted mid-CLEAR: the clear aborts and clr_busy=0; contents are partially cleared and undefined.
- No read/write ordering guarantee is given beyond single-cycle conflict arbitration.

Optional Feature:
- Macro: OUTMEM_PARITY_EN.
- Defined:
  - Each stored word carries an extra even-parity bit computed on write; clear writes parity 0.
  - On read, parity is recomputed.
  - rd_parity_err=1 alongside rd_valid on a mismatch; otherwise 0.
- Undefined:
  - No parity storage.
  - rd_parity_err is tied to 0.

Test Plan:
- Write 0xDEADBEEF to addr 5, then read addr 5 → rd_valid one cycle after the read handshake, rd_data=0xDEADBEEF.
- Same cycle: write addr 8 and read addr 12 (both bank 0) → rd_ready=0 for 1 cycle, the write completes, the read is accepted next cycle. Same cycle: write addr 8 and read addr 9 → both accepted.
- Fill addrs 0..15 with nonzero data, pulse clr_start → clr_busy high for exactly ROWS cycles, wr_ready/rd_ready=0 during; afterwards reads of 0..15 return 0.
- Write to addr 301056 → err_oor=1, subsequent read of 301056 returns 0 with rd_valid=1; clr_start clears err_oor.
- Assert rst mid-CLEAR at row 100 → clr_busy=0, rd_valid=0, rd_data=0 immediately; the FSM accepts new writes after rst deasserts.
- With OUTMEM_PARITY_EN: force-flip one stored bit via backdoor, read it → rd_parity_err=1 with rd_valid; a clean word gives rd_parity_err=0.

Source files
------------

// File: rtl/output_memory_banked.sv
// output_memory_banked: banked single-port result SRAM for the conv/MLP engines.
// NBANK word-interleaved banks with valid/ready write and read ports.
// When write and read target the same bank, the write is served and the read stalls.
// A zero-fill sequencer clears the whole array, and a sticky flag records out-of-range accesses.
// Optional feature macro OUTMEM_PARITY_EN: stores an even-parity bit per word and checks it on read.
module output_memory_banked #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 301056,
    parameter int unsigned NBANK = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_start,
    output logic          clr_busy,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid_in,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          err_oor,
    output logic          rd_parity_err
);

    localparam int unsigned BW   = $clog2(NBANK);
    localparam int unsigned ROWS = (DEPTH + NBANK - 1) / NBANK;
    localparam int unsigned RW   = $clog2(ROWS);
`ifdef OUTMEM_PARITY_EN
    localparam int unsigned MW   = DW + 1;
`else
    localparam int unsigned MW   = DW;
`endif

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state;
    logic [RW-1:0]    clr_row;
    logic             clr_last;

    // One storage word per bank row; index [bank][row]
    logic [MW-1:0]    mem [NBANK][ROWS];

    logic [BW-1:0]    wr_bank;
    logic [BW-1:0]    rd_bank;
    logic [RW-1:0]    wr_row;
    logic [RW-1:0]    rd_row;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_fire;
    logic             rd_fire;
    logic             oor_hit;

    logic [NBANK-1:0] bank_we;
    logic [RW-1:0]    port_row;
    logic [MW-1:0]    port_word;
    logic [MW-1:0]    rd_word;

    // Address decode: low bits select the bank, upper bits select the row
    assign wr_bank     = wr_addr[BW-1:0];
    assign rd_bank     = rd_addr[BW-1:0];
    assign wr_row      = RW'(wr_addr >> BW);
    assign rd_row      = RW'(rd_addr >> BW);
    assign wr_in_range = 32'(wr_addr) < DEPTH;
    assign rd_in_range = 32'(rd_addr) < DEPTH;

    // Handshakes: the whole array is locked during clear; a same-bank read yields to the write
    assign wr_ready = (state == ST_IDLE);
    assign rd_ready = (state == ST_IDLE) && !(wr_valid && (wr_bank == rd_bank));
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid_in && rd_ready;
    assign oor_hit  = (wr_fire && !wr_in_range) || (rd_fire && !rd_in_range);
    assign clr_last = (clr_row == RW'(ROWS - 1));

    // Shared write port: clear drives every bank at the clear row; otherwise only the addressed bank is written
    always_comb begin
        bank_we   = '0;
        port_row  = wr_row;
        port_word = '0;
        if (state == ST_CLEAR) begin
            bank_we  = '1;
            port_row = clr_row;
        end else if (wr_fire && wr_in_range) begin
            bank_we[wr_bank] = 1'b1;
`ifdef OUTMEM_PARITY_EN
            port_word = {^wr_data, wr_data};
`else
            port_word = wr_data;
`endif
        end
    end

    // Bank arrays: at most one write per bank per cycle; contents are not reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < NBANK; b++) begin
            if (bank_we[b]) begin
                mem[b][port_row] <= port_word;
            end
        end
    end

    assign rd_word = mem[rd_bank][rd_row];

    // Control FSM: IDLE serves traffic; CLEAR sweeps rows 0..ROWS-1 once and then returns to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            clr_row  <= '0;
            clr_busy <= 1'b0;
            err_oor  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state    <= ST_CLEAR;
                        clr_row  <= '0;
                        clr_busy <= 1'b1;
                        // Clear restarts error tracking, but a same-cycle out-of-range access is still recorded
                        err_oor  <= oor_hit;
                    end else begin
                        err_oor  <= err_oor || oor_hit;
                    end
                end
                ST_CLEAR: begin
                    if (clr_last) begin
                        state    <= ST_IDLE;
                        clr_row  <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        clr_row  <= clr_row + RW'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef OUTMEM_PARITY_EN
    // Read data register with parity check; an out-of-range read returns zero with no parity error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data       <= '0;
            rd_valid      <= 1'b0;
            rd_parity_err <= 1'b0;
        end else begin
            rd_valid      <= rd_fire;
            rd_parity_err <= rd_fire && rd_in_range && (^rd_word);
            if (rd_fire) begin
                rd_data <= rd_in_range ? rd_word[DW-1:0] : '0;
            end
        end
    end
`else
    // Read data register; holds until the next accepted read, and an out-of-range read returns zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= rd_in_range ? rd_word[DW-1:0] : '0;
            end
        end
    end

    assign rd_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_output_memory_banked.sv
// tb_output_memory_banked: randomized self-checking bench for output_memory_banked.
// An address-keyed reference model tracks memory contents.
// Expected results are derived from the bank-conflict, latency and range rules.
module tb_output_memory_banked;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 301056;
    localparam int unsigned NBANK = 4;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned ROWS  = (DEPTH + NBANK - 1) / NBANK;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_start;
    logic          clr_busy;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid_in;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          err_oor;
    logic          rd_parity_err;

    int errors = 0;
    int checks = 0;

    // Reference model: known word values by address; all_zero means every unlisted in-range word is 0
    logic [DW-1:0] mdl [int];
    bit            all_zero = 1'b0;
    logic [DW-1:0] last_rd = '0;

    output_memory_banked dut (
        .clk          (clk),
        .rst          (rst),
        .clr_start    (clr_start),
        .clr_busy     (clr_busy),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_valid_in  (rd_valid_in),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .err_oor      (err_oor),
        .rd_parity_err(rd_parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] exp_rd(int a);
        if (a >= int'(DEPTH)) return '0;
        if (mdl.exists(a)) return mdl[a];
        return '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr_start   = 1'b0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        rd_valid_in = 1'b0;
        rd_addr     = '0;
    endtask

    // Single write transaction, one cycle
    task automatic do_write(int a, logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = AW'(a);
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
        if (a < int'(DEPTH)) mdl[a] = d;
    endtask

    // Single read transaction; returns the data observed one cycle after acceptance
    task automatic do_read(int a, output logic v, output logic [DW-1:0] d, output logic pe);
        rd_valid_in = 1'b1;
        rd_addr     = AW'(a);
        tick();
        rd_valid_in = 1'b0;
        v  = rd_valid;
        d  = rd_data;
        pe = rd_parity_err;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy: got %b want 0", clr_busy); end
        checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL reset_err_oor: got %b want 0", err_oor); end
        checks++; if (rd_parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity: got %b want 0", rd_parity_err); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (wr_ready !== 1'b1 || rd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got wr=%b rd=%b want 1 1", wr_ready, rd_ready); end
    endtask

    task automatic test_write_read();
        wr_valid = 1'b1; wr_addr = AW'(5); wr_data = 32'hDEADBEEF;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_idle: got %b want 1", wr_ready); end
        tick();
        mdl[5] = 32'hDEADBEEF;
        wr_valid = 1'b0;
        rd_valid_in = 1'b1; rd_addr = AW'(5);
        #1;
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL rd_ready_idle: got %b want 1", rd_ready); end
        tick();
        rd_valid_in = 1'b0;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_valid: got %b want 1", rd_valid); end
        checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data: got %h want deadbeef", rd_data); end
        last_rd = 32'hDEADBEEF;
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse: got %b want 0", rd_valid); end
        checks++; if (rd_data !== last_rd) begin errors++; $display("FAIL rd_data_hold: got %h want %h", rd_data, last_rd); end
    endtask

    task automatic test_conflict();
        logic [DW-1:0] v;
        do_write(12, $urandom);
        do_write(9, $urandom);
        // Write 8 and read 12 share bank 0: the read stalls for one cycle
        v = $urandom;
        wr_valid = 1'b1; wr_addr = AW'(8); wr_data = v;
        rd_valid_in = 1'b1; rd_addr = AW'(12);
        #1;
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL conflict_rd_ready: got %b want 0", rd_ready); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL conflict_wr_ready: got %b want 1", wr_ready); end
        tick();
        mdl[8] = v;
        wr_valid = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL conflict_no_read: got %b want 0", rd_valid); end
        #1;
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL conflict_retry_ready: got %b want 1", rd_ready); end
        tick();
        rd_valid_in = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== exp_rd(12)) begin errors++; $display("FAIL conflict_read12: got v=%b d=%h want 1 %h", rd_valid, rd_data, exp_rd(12)); end
        // Same address in the same cycle: stall, then read returns the new data
        v = $urandom;
        wr_valid = 1'b1; wr_addr = AW'(8); wr_data = v;
        rd_valid_in = 1'b1; rd_addr = AW'(8);
        #1;
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL same_addr_rd_ready: got %b want 0", rd_ready); end
        tick();
        mdl[8] = v;
        wr_valid = 1'b0;
        tick();
        rd_valid_in = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== v) begin errors++; $display("FAIL same_addr_data: got v=%b d=%h want 1 %h", rd_valid, rd_data, v); end
        // Different banks proceed in parallel
        v = $urandom;
        wr_valid = 1'b1; wr_addr = AW'(8); wr_data = v;
        rd_valid_in = 1'b1; rd_addr = AW'(9);
        #1;
        checks++; if (rd_ready !== 1'b1 || wr_ready !== 1'b1) begin errors++; $display("FAIL parallel_ready: got wr=%b rd=%b want 1 1", wr_ready, rd_ready); end
        tick();
        mdl[8] = v;
        wr_valid = 1'b0;
        rd_addr = AW'(8);
        checks++; if (rd_valid !== 1'b1 || rd_data !== exp_rd(9)) begin errors++; $display("FAIL parallel_read9: got v=%b d=%h want 1 %h", rd_valid, rd_data, exp_rd(9)); end
        // Back-to-back: read of 8 right after its write returns the new value
        tick();
        rd_valid_in = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== v) begin errors++; $display("FAIL back_to_back: got v=%b d=%h want 1 %h", rd_valid, rd_data, v); end
        last_rd = rd_data;
    endtask

    task automatic test_random();
        int  wq[$];
        bit  inq [int];
        foreach (mdl[k]) begin
            wq.push_back(k);
            inq[k] = 1'b1;
        end
        for (int i = 0; i < 400; i++) begin
            logic          wv;
            logic          rv;
            logic          exp_rdy;
            logic          fire;
            int            wa;
            int            ra;
            logic [DW-1:0] wd;
            logic [DW-1:0] ed;
            wv = 1'($urandom_range(0, 1));
            wa = int'($urandom_range(0, 63));
            wd = $urandom;
            rv = 1'($urandom_range(0, 1));
            ra = wq[$urandom_range(0, wq.size() - 1)];
            wr_valid = wv; wr_addr = AW'(wa); wr_data = wd;
            rd_valid_in = rv; rd_addr = AW'(ra);
            #1;
            exp_rdy = !(wv && ((wa % NBANK) == (ra % NBANK)));
            checks++; if (rd_ready !== exp_rdy) begin errors++; $display("FAIL rand_rd_ready[%0d]: got %b want %b (wa=%0d ra=%0d)", i, rd_ready, exp_rdy, wa, ra); end
            fire = rv && exp_rdy;
            ed = exp_rd(ra);
            if (wv) begin
                mdl[wa] = wd;
                if (!inq.exists(wa)) begin
                    inq[wa] = 1'b1;
                    wq.push_back(wa);
                end
            end
            tick();
            if (fire) last_rd = ed;
            checks++; if (rd_valid !== fire) begin errors++; $display("FAIL rand_rd_valid[%0d]: got %b want %b", i, rd_valid, fire); end
            checks++; if (rd_data !== last_rd) begin errors++; $display("FAIL rand_rd_data[%0d]: got %h want %h (ra=%0d)", i, rd_data, last_rd, ra); end
            checks++; if (rd_parity_err !== 1'b0) begin errors++; $display("FAIL rand_parity[%0d]: got %b want 0", i, rd_parity_err); end
        end
        idle();
    endtask

    task automatic test_oor();
        logic          v;
        logic          pe;
        logic [DW-1:0] d;
        wr_valid = 1'b1; wr_addr = AW'(DEPTH); wr_data = 32'hFFFFFFFF;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL oor_wr_ready: got %b want 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        checks++; if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_wr_flag: got %b want 1", err_oor); end
        do_read(5, v, d, pe);
        checks++; if (d !== exp_rd(5)) begin errors++; $display("FAIL oor_pre_read: got %h want %h", d, exp_rd(5)); end
        do_read(int'(DEPTH), v, d, pe);
        checks++; if (v !== 1'b1 || d !== '0) begin errors++; $display("FAIL oor_read: got v=%b d=%h want 1 0", v, d); end
        checks++; if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_sticky: got %b want 1", err_oor); end
        last_rd = '0;
    endtask

    task automatic test_clear();
        logic          v;
        logic          pe;
        logic [DW-1:0] d;
        int            busy;
        int            bad;
        for (int a = 0; a < 16; a++) do_write(a, $urandom | 32'h1);
        do_read(3, v, d, pe);
        checks++; if (d !== mdl[3] || d === '0) begin errors++; $display("FAIL clear_prefill: got %h want %h", d, mdl[3]); end
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL clear_busy_start: got %b want 1", clr_busy); end
        checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL clear_err_oor: got %b want 0", err_oor); end
        // Hold requests during the clear; none may be accepted and the write must not land
        wr_valid = 1'b1; wr_addr = AW'(3); wr_data = 32'h12345678;
        rd_valid_in = 1'b1; rd_addr = AW'(6);
        busy = 0;
        bad = 0;
        while (clr_busy === 1'b1 && busy < int'(ROWS) + 16) begin
            busy++;
            if (wr_ready !== 1'b0 || rd_ready !== 1'b0 || rd_valid !== 1'b0) bad++;
            clr_start = (busy == 50);
            tick();
        end
        idle();
        checks++; if (busy != int'(ROWS)) begin errors++; $display("FAIL clear_duration: got %0d want %0d cycles", busy, ROWS); end
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_ready_low: got %0d cycles with handshake activity want 0", bad); end
        mdl.delete();
        all_zero = 1'b1;
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            do_read(a, v, d, pe);
            if (v !== 1'b1 || d !== '0) bad++;
        end
        do_read(300000, v, d, pe);
        if (v !== 1'b1 || d !== '0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_readback: got %0d nonzero/invalid reads want 0", bad); end
        last_rd = '0;
    endtask

    task automatic test_reset_mid_clear();
        logic          v;
        logic          pe;
        logic [DW-1:0] d;
        logic [DW-1:0] val;
        val = $urandom | 32'h100;
        do_write(40, val);
        do_read(40, v, d, pe);
        checks++; if (d !== val) begin errors++; $display("FAIL rmc_pre_read: got %h want %h", d, val); end
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (100) tick();
        checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL rmc_busy_mid: got %b want 1", clr_busy); end
        rst = 1'b1;
        #2;
        checks++; if (clr_busy !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL rmc_async: got busy=%b v=%b d=%h want 0 0 0", clr_busy, rd_valid, rd_data); end
        @(negedge clk);
        rst = 1'b0;
        mdl.delete();
        all_zero = 1'b0;
        val = $urandom;
        wr_valid = 1'b1; wr_addr = AW'(7); wr_data = val;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rmc_wr_ready: got %b want 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        mdl[7] = val;
        do_read(7, v, d, pe);
        checks++; if (v !== 1'b1 || d !== val) begin errors++; $display("FAIL rmc_readback: got v=%b d=%h want 1 %h", v, d, val); end
        last_rd = d;
    endtask

`ifdef OUTMEM_PARITY_EN
    task automatic test_parity();
        logic          v;
        logic          pe;
        logic [DW-1:0] d;
        do_write(21, $urandom);
        do_write(22, $urandom);
        // Address 21 lives in bank 1, row 5
        dut.mem[1][5][4] = ~dut.mem[1][5][4];
        do_read(21, v, d, pe);
        checks++; if (v !== 1'b1 || pe !== 1'b1) begin errors++; $display("FAIL parity_flip: got v=%b pe=%b want 1 1", v, pe); end
        do_read(22, v, d, pe);
        checks++; if (v !== 1'b1 || pe !== 1'b0 || d !== mdl[22]) begin errors++; $display("FAIL parity_clean: got v=%b pe=%b d=%h want 1 0 %h", v, pe, d, mdl[22]); end
        tick();
        checks++; if (rd_parity_err !== 1'b0) begin errors++; $display("FAIL parity_pulse: got %b want 0", rd_parity_err); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_write_read();
        test_conflict();
        test_random();
        test_oor();
        test_clear();
        test_reset_mid_clear();
`ifdef OUTMEM_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
